alu_sequencer: RTL and testbench

- Operand/issue stage directly upstream of the 32-bit ALU. It holds the general-purpose register file and accepts encoded ALU instructions over a valid/ready handshake.
- Per instruction it drives the ALU operands, FunSel and carry-in, then waits out the ALU's registered result and flag latency. It writes the result back to the register file and optionally latches the Z|C|N|V flags.
- A host load port initialises registers, and a combinational read port exposes any register.

---
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Host-side bundle of the ALU sequencer: instruction handshake, register load port, read port.
// The host holds the master end and the sequencer holds the slave end.
interface alu_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [14:0]       instr;
  logic              ld_en;
  logic              ld_ready;
  logic [2:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [2:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
    input  instr_ready, ld_ready, rd_data
  );

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
    output instr_ready, ld_ready, rd_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Operand/issue stage ahead of the 32-bit ALU: owns the register file, issues one instruction per 4 cycles.
// Latency: accept T0, writeback T3, done in first IDLE cycle; backpressure: instr_ready/ld_ready low while busy.
module alu_sequencer #(
  parameter int NREG   = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  alu_sequencer_if.slave    host,
  output logic [4:0]        alu_funsel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic [4:0] funsel;
    logic [2:0] dst;
    logic [2:0] srca;
    logic [2:0] srcb;
    logic       set_flags;
  } instr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESULT, FLAGS} state_t;

  state_t            state;
  instr_t            instr_d;
  logic [2:0]        dst_q;
  logic              set_flags_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] regs [NREG];

  assign instr_d          = host.instr;
  assign host.instr_ready = (state == IDLE);
  assign host.ld_ready    = (state == IDLE);
  assign host.rd_data     = regs[host.rd_addr];
  assign busy             = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      flags_q     <= '0;
      alu_funsel  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cin     <= 1'b0;
      done        <= 1'b0;
      dst_q       <= '0;
      set_flags_q <= 1'b0;
      result_q    <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Operands are read from the pre-load register values when a load coincides.
          if (host.ld_en) begin
            regs[host.ld_addr] <= host.ld_data;
          end
          if (host.instr_valid) begin
            alu_a       <= regs[instr_d.srca];
            alu_b       <= regs[instr_d.srcb];
            alu_funsel  <= instr_d.funsel;
            alu_cin     <= flags_q[2];
            dst_q       <= instr_d.dst;
            set_flags_q <= instr_d.set_flags;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= RESULT;
        end
        RESULT: begin
          result_q <= alu_out;
          state    <= FLAGS;
        end
        FLAGS: begin
          regs[dst_q] <= result_q;
          if (set_flags_q) begin
            flags_q <= alu_flags;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a registered ALU model and a scoreboard of expected writebacks.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  alu_funsel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_out = '0;
  logic [3:0]  alu_flags = '0;
  logic [3:0]  fl_d = '0;
  logic [3:0]  flags_q;
  logic        busy;
  logic        done;

  alu_sequencer_if hif ();

  alu_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .host       (hif),
    .alu_funsel (alu_funsel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .flags_q    (flags_q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  dst;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        sf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_r [8];
  logic [3:0]  m_fl;
  int          n_checks = 0;
  int          n_fail = 0;

  // {result[31:0], Z, C, N, V}
  function automatic logic [35:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [32:0] s;
    logic        v;
    case (f)
      5'b10100: begin s = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (s[31] != a[31]); end
      5'b10101: begin s = {1'b0, a} + {1'b0, b} + {32'd0, cin}; v = (a[31] == b[31]) && (s[31] != a[31]); end
      5'b10110: begin s = {1'b0, a} - {1'b0, b}; v = (a[31] != b[31]) && (s[31] != a[31]); end
      default:  begin s = {1'b0, a ^ b}; v = 1'b0; end
    endcase
    return {s[31:0], (s[31:0] == 32'd0), s[32], s[31], v};
  endfunction

  // ALU model: result one cycle after sampling, flags one cycle after the result.
  always @(posedge clock) begin
    logic [35:0] r;
    r = ref_alu(alu_funsel, alu_a, alu_b, alu_cin);
    alu_out   <= r[35:4];
    fl_d      <= r[3:0];
    alu_flags <= fl_d;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    hif.rd_addr = a;
    #1;
    v = hif.rd_data;
  endtask

  task automatic host_load(input logic [2:0] a, input logic [31:0] d);
    hif.ld_en   = 1'b1;
    hif.ld_addr = a;
    hif.ld_data = d;
    step();
    hif.ld_en = 1'b0;
    m_r[a]    = d;
  endtask

  task automatic drive_instr(input logic [4:0] f, input logic [2:0] d, input logic [2:0] a,
                             input logic [2:0] b, input logic sf);
    logic [35:0] r;
    exp_t        e;
    r     = ref_alu(f, m_r[a], m_r[b], m_fl[2]);
    e.dst = d;
    e.res = r[35:4];
    e.fl  = r[3:0];
    e.sf  = sf;
    sb.push_back(e);
    hif.instr       = {f, d, a, b, sf};
    hif.instr_valid = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hif.instr_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output bit ok, output int cyc, output exp_t e);
    ok  = 1'b0;
    cyc = 0;
    e   = '{dst: 3'd0, res: 32'd0, fl: 4'd0, sf: 1'b0};
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (done && sb.size() > 0) begin
        ok = 1'b1;
        e  = sb.pop_front();
        m_r[e.dst] = e.res;
        if (e.sf) m_fl = e.fl;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_checks++; if (hif.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_instr_ready got %b want 1", hif.instr_ready); end
    n_checks++; if (hif.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", hif.ld_ready); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags_q); end
    n_checks++; if ({alu_funsel, alu_a, alu_b, alu_cin} !== 70'd0) begin n_fail++; $display("FAIL reset_alu_outs got %h %h %h %b want zeros", alu_funsel, alu_a, alu_b, alu_cin); end
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], v);
      n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", i, v); end
    end
  endtask

  task automatic test_add();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    host_load(3'd1, 32'd5);
    host_load(3'd2, 32'd3);
    drive_instr(5'b10100, 3'd3, 3'd1, 3'd2, 1'b1);
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL add_accept timed out"); end
    n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin n_fail++; $display("FAIL add_operands got %h %h want 5 3", alu_a, alu_b); end
    n_checks++; if (alu_funsel !== 5'b10100 || alu_cin !== 1'b0) begin n_fail++; $display("FAIL add_funsel_cin got %b %b want 10100 0", alu_funsel, alu_cin); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (hif.instr_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL add_ready_low cyc%0d got rdy=%b busy=%b want 0 1", k, hif.instr_ready, busy); end
      if (k < 2) step();
    end
    rd(3'd3, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL add_early_write got %h want 0", v); end
    wait_done(ok, cyc, e);
    n_checks++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL add_done_timing got ok=%0d cyc=%0d want 1 1", ok, cyc); end
    rd(3'd3, v);
    n_checks++; if (v !== e.res || v !== 32'd8) begin n_fail++; $display("FAIL add_r3 got %h want %h", v, e.res); end
    n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL add_flags got %b want 0000", flags_q); end
    n_checks++; if (hif.instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_back got %b want 1", hif.instr_ready); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got %b want 0", done); end
    n_checks++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL add_alu_hold got %h want 5", alu_a); end
  endtask

  task automatic test_sub_zero();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    drive_instr(5'b10110, 3'd4, 3'd1, 3'd1, 1'b1);
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    wait_done(ok, cyc, e);
    n_checks++; if (!ok || cyc != 3) begin n_fail++; $display("FAIL sub_done got ok=%0d cyc=%0d want 1 3", ok, cyc); end
    rd(3'd4, v);
    n_checks++; if (v !== e.res) begin n_fail++; $display("FAIL sub_r4 got %h want %h", v, e.res); end
    n_checks++; if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL sub_flags got %b want 1000", flags_q); end
  endtask

  task automatic test_carry();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    host_load(3'd5, 32'hFFFF_FFFF);
    host_load(3'd6, 32'd1);
    drive_instr(5'b10100, 3'd7, 3'd5, 3'd6, 1'b1);
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    wait_done(ok, cyc, e);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL carry_done timed out"); end
    rd(3'd7, v);
    n_checks++; if (v !== e.res) begin n_fail++; $display("FAIL carry_r7 got %h want %h", v, e.res); end
    n_checks++; if (flags_q !== 4'b1100) begin n_fail++; $display("FAIL carry_flags got %b want 1100", flags_q); end
  endtask

  task automatic test_no_flags();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    drive_instr(5'b10100, 3'd3, 3'd1, 3'd2, 1'b0);
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    n_checks++; if (alu_cin !== 1'b1) begin n_fail++; $display("FAIL noflags_cin got %b want 1", alu_cin); end
    wait_done(ok, cyc, e);
    rd(3'd3, v);
    n_checks++; if (!ok || v !== e.res) begin n_fail++; $display("FAIL noflags_r3 got %h want %h", v, e.res); end
    n_checks++; if (flags_q !== 4'b1100 || flags_q !== m_fl) begin n_fail++; $display("FAIL noflags_flags got %b want 1100", flags_q); end
  endtask

  task automatic test_load_collision();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    drive_instr(5'b10100, 3'd3, 3'd3, 3'd2, 1'b0);
    hif.ld_en   = 1'b1;
    hif.ld_addr = 3'd3;
    hif.ld_data = 32'd77;
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    hif.ld_en       = 1'b0;
    m_r[3]          = 32'd77;
    n_checks++; if (alu_a !== 32'd8) begin n_fail++; $display("FAIL collide_preload_operand got %h want 8", alu_a); end
    rd(3'd3, v);
    n_checks++; if (v !== 32'd77) begin n_fail++; $display("FAIL collide_load got %h want 4d", v); end
    wait_done(ok, cyc, e);
    rd(3'd3, v);
    n_checks++; if (!ok || v !== e.res || v !== 32'd11) begin n_fail++; $display("FAIL collide_writeback got %h want %h", v, e.res); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] v;
    drive_instr(5'b10100, 3'd4, 3'd1, 3'd2, 1'b1);
    wait_accept(ok);
    hif.instr_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0 || hif.instr_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_state got busy=%b rdy=%b want 0 1", busy, hif.instr_ready); end
    n_checks++; if (flags_q !== 4'b0000 || alu_a !== 32'd0) begin n_fail++; $display("FAIL midreset_clear got flags=%b a=%h want 0 0", flags_q, alu_a); end
    sb.delete();
    for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
    m_fl    = 4'b0000;
    reset_n = 1'b1;
    step();
    n_checks++; if (hif.instr_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", hif.instr_ready); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done cyc%0d got %b want 0", k, done); end
      step();
    end
    rd(3'd4, v);
    n_checks++; if (v !== 32'd0 || flags_q !== 4'b0000) begin n_fail++; $display("FAIL midreset_regs got r4=%h flags=%b want 0 0", v, flags_q); end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; exp_t e; logic [31:0] v;
    host_load(3'd1, 32'd5);
    host_load(3'd2, 32'd3);
    drive_instr(5'b10100, 3'd6, 3'd1, 3'd2, 1'b1);
    wait_accept(ok);
    drive_instr(5'b10100, 3'd5, 3'd1, 3'd1, 1'b0);
    hif.ld_en   = 1'b1;
    hif.ld_addr = 3'd1;
    hif.ld_data = 32'd99;
    n_checks++; if (hif.ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ld_ready got %b want 0", hif.ld_ready); end
    step();
    hif.ld_en = 1'b0;
    wait_done(ok, cyc, e);
    rd(3'd6, v);
    n_checks++; if (!ok || v !== e.res) begin n_fail++; $display("FAIL b2b_first got %h want %h", v, e.res); end
    n_checks++; if (hif.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got %b want 1", hif.instr_ready); end
    step();
    hif.instr_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd5) begin n_fail++; $display("FAIL b2b_second_accept got busy=%b a=%h b=%h want 1 5 5", busy, alu_a, alu_b); end
    wait_done(ok, cyc, e);
    n_checks++; if (!ok || cyc != 3) begin n_fail++; $display("FAIL b2b_second_done got ok=%0d cyc=%0d want 1 3", ok, cyc); end
    rd(3'd5, v);
    n_checks++; if (v !== e.res) begin n_fail++; $display("FAIL b2b_second_r5 got %h want %h", v, e.res); end
    rd(3'd1, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL b2b_ld_ignored got %h want 5", v); end
    n_checks++; if (flags_q !== m_fl) begin n_fail++; $display("FAIL b2b_flags got %b want %b", flags_q, m_fl); end
    step(); step(); step();
    n_checks++; if (busy !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL b2b_no_dup got busy=%b pending=%0d want 0 0", busy, sb.size()); end
  endtask

  initial begin
    hif.instr_valid = 1'b0;
    hif.instr       = '0;
    hif.ld_en       = 1'b0;
    hif.ld_addr     = '0;
    hif.ld_data     = '0;
    hif.rd_addr     = '0;
    for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
    m_fl = 4'b0000;
    #23;
    reset_n = 1'b1;
    step();
    test_reset();
    test_add();
    test_sub_zero();
    test_carry();
    test_no_flags();
    test_load_collision();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
